// File: rtl/button_conditioner.sv
// button_conditioner: synchronize, debounce and classify a push-button into level, press/release/long pulses and a run/stop toggle
module button_conditioner #(
  parameter logic [31:0] DEBOUNCE_MAX = 32'd1_000_000,
  parameter logic [31:0] LONG_MAX = 32'd200_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic toggle
);
  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;
  state_t state, state_d;
  logic s1, s2, long_flag;
  logic [31:0] deb_cnt, hold_cnt;
  logic deb_done, hold_done, press_d, release_d, long_d;
  assign deb_done = deb_cnt == DEBOUNCE_MAX - 32'd1;
  assign hold_done = hold_cnt == LONG_MAX - 32'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      state <= IDLE;
    end else begin
      s1 <= button;
      s2 <= s1;
      state <= state_d;
    end
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:        state_d = s2 ? DEB_PRESS : IDLE;
      DEB_PRESS:   state_d = !s2 ? IDLE : deb_done ? HELD : DEB_PRESS;
      HELD:        state_d = s2 ? HELD : DEB_RELEASE;
      DEB_RELEASE: state_d = s2 ? HELD : deb_done ? IDLE : DEB_RELEASE;
      default:     state_d = IDLE;
    endcase
  end
  always_comb begin
    press_d = state == DEB_PRESS && s2 && deb_done;
    release_d = state == DEB_RELEASE && !s2 && deb_done;
    long_d = state == HELD && hold_done && !long_flag;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt <= '0;
      hold_cnt <= '0;
      long_flag <= 1'b0;
      btn_level <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse <= 1'b0;
      toggle <= 1'b0;
    end else begin
      deb_cnt <= state_d != state ? '0 : (state == DEB_PRESS || state == DEB_RELEASE) ? deb_cnt + 32'd1 : deb_cnt;
      hold_cnt <= press_d ? '0 : (state == HELD && s2 && !hold_done) ? hold_cnt + 32'd1 : hold_cnt;
      long_flag <= press_d ? 1'b0 : long_d ? 1'b1 : long_flag;
      btn_level <= press_d ? 1'b1 : release_d ? 1'b0 : btn_level;
      press_pulse <= press_d;
      release_pulse <= release_d;
      long_pulse <= long_d;
      toggle <= long_d ? 1'b0 : (release_d && !long_flag) ? ~toggle : toggle;
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench for button_conditioner with directed presses, bounces, long holds and resets
module tb_button_conditioner;
  typedef struct {int kind; int cyc; logic tog; logic lvl;} ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button = 1'b0;
  logic btn_level, press_pulse, release_pulse, long_pulse, toggle;
  logic rst_q = 1'b0;
  logic [2:0] pv;
  int edges = 0;
  int checks = 0;
  int errors = 0;
  ev_t q[$];
  ev_t e;
  button_conditioner #(.DEBOUNCE_MAX(32'd4), .LONG_MAX(32'd16)) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .toggle(toggle)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    edges <= edges + 1;
    rst_q <= rst;
  end
  always @(negedge clk) begin
    if (rst_q) begin
      checks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse, toggle} !== 5'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%b expected=00000", edges,
                 {btn_level, press_pulse, release_pulse, long_pulse, toggle});
      end
    end
    pv = {long_pulse, release_pulse, press_pulse};
    for (int k = 0; k < 3; k++) begin
      if (pv[k] === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event kind=%0d cyc=%0d expected none", k, edges);
        end else begin
          e = q.pop_front();
          if (e.kind != k || e.cyc != edges || e.tog !== toggle || e.lvl !== btn_level) begin
            errors++;
            $display("FAIL event got kind=%0d cyc=%0d tog=%b lvl=%b expected kind=%0d cyc=%0d tog=%b lvl=%b",
                     k, edges, toggle, btn_level, e.kind, e.cyc, e.tog, e.lvl);
          end
        end
      end
    end
  end
  task automatic chk(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", name, act, exp);
    end
  endtask
  task automatic push(int kind, int cyc, logic tog, logic lvl);
    ev_t n;
    n.kind = kind;
    n.cyc = cyc;
    n.tog = tog;
    n.lvl = lvl;
    q.push_back(n);
  endtask
  task automatic short_press(int n, logic tp, logic tr);
    int e0;
    e0 = edges;
    button = 1'b1;
    push(0, e0 + 7, tp, 1'b1);
    repeat (n) @(negedge clk);
    button = 1'b0;
    push(1, e0 + n + 7, tr, 1'b0);
    repeat (12) @(negedge clk);
  endtask
  initial begin
    int e0;
    repeat (3) begin
      @(negedge clk);
      button = ~button;
    end
    rst = 1'b0;
    button = 1'b0;
    repeat (5) @(negedge clk);
    short_press(12, 1'b0, 1'b1);
    button = 1'b1;
    repeat (2) @(negedge clk);
    button = 1'b0;
    repeat (3) @(negedge clk);
    button = 1'b1;
    repeat (2) @(negedge clk);
    button = 1'b0;
    repeat (10) @(negedge clk);
    chk("bounce_level", btn_level, 1'b0);
    chk("bounce_toggle", toggle, 1'b1);
    e0 = edges;
    button = 1'b1;
    push(0, e0 + 7, 1'b1, 1'b1);
    push(2, e0 + 23, 1'b0, 1'b1);
    repeat (30) @(negedge clk);
    button = 1'b0;
    push(1, e0 + 37, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    short_press(8, 1'b0, 1'b1);
    short_press(8, 1'b1, 1'b0);
    e0 = edges;
    button = 1'b1;
    push(0, e0 + 7, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push(0, e0 + 18, 1'b0, 1'b1);
    repeat (13) @(negedge clk);
    button = 1'b0;
    push(1, e0 + 31, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    e0 = edges;
    button = 1'b1;
    push(0, e0 + 7, 1'b1, 1'b1);
    push(2, e0 + 23, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    button = 1'b0;
    push(1, e0 + 27, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got=%0d pending expected=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_MAX, default 32'd1_000_000, is the number of stable cycles needed to accept a level change (10 ms at 100 MHz; bench uses 32'd4).
REQ-002 Parameter LONG_MAX, default 32'd200_000_000, is the number of debounced-held cycles needed to flag a long press (2 s at 100 MHz; bench uses 32'd16).
REQ-003 clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 button  input  1  raw, asynchronous, bouncing push-button level, active-high.
REQ-006 btn_level  output  1  debounced button level.
REQ-007 press_pulse  output  1  one-cycle pulse on an accepted press.
REQ-008 release_pulse  output  1  one-cycle pulse on an accepted release.
REQ-009 long_pulse  output  1  one-cycle pulse when a press has been held LONG_MAX cycles.
REQ-010 toggle  output  1  run/stop level for the downstream light stage; flips on each short press.

Function
REQ-011 button passes through a two-flop synchronizer (s1, s2); only s2 is used by the remaining logic.
REQ-012 State machine states: IDLE, DEB_PRESS, HELD, DEB_RELEASE; 32-bit debounce counter deb_cnt; 32-bit hold counter hold_cnt; flag long_flag.
REQ-013 IDLE: s2=1 -> DEB_PRESS, deb_cnt<=0; otherwise stay.
REQ-014 DEB_PRESS: s2=0 -> IDLE, deb_cnt<=0, no pulse (bounce rejected); s2=1 and deb_cnt<DEBOUNCE_MAX-1 -> deb_cnt+1; s2=1 and deb_cnt==DEBOUNCE_MAX-1 -> HELD, btn_level<=1, press_pulse<=1, hold_cnt<=0, long_flag<=0.
REQ-015 HELD: s2=0 -> DEB_RELEASE, deb_cnt<=0; otherwise hold_cnt increments, saturating at LONG_MAX-1.
REQ-016 HELD: when hold_cnt==LONG_MAX-1 and long_flag==0 -> long_pulse<=1, long_flag<=1, toggle<=0; long_pulse fires at most once per press.
REQ-017 DEB_RELEASE: s2=1 -> HELD, hold_cnt kept (not cleared), no pulse; s2=0 and deb_cnt<DEBOUNCE_MAX-1 -> deb_cnt+1; s2=0 and deb_cnt==DEBOUNCE_MAX-1 -> IDLE, btn_level<=0, release_pulse<=1.
REQ-018 On the accepted release of REQ-017: toggle<=~toggle if long_flag==0; toggle unchanged if long_flag==1.
REQ-019 press_pulse, release_pulse and long_pulse are registered and high for exactly one cycle; default 0 every other cycle.
REQ-020 Latency: with button held high and clean, counting the first edge that samples it high as edge 1, press_pulse and btn_level go high after edge DEBOUNCE_MAX+3; release has identical latency.
REQ-021 If hold_cnt reaches LONG_MAX-1 in the same cycle that s2 falls, long_pulse still fires and the state moves to DEB_RELEASE.
REQ-022 Counter comparisons are 32-bit unsigned; DEBOUNCE_MAX and LONG_MAX are each >=2.

Reset
REQ-023 rst=1 at a clock edge forces IDLE, s1=s2=0, deb_cnt=hold_cnt=0, long_flag=0, and all outputs 0, regardless of state or button.
REQ-024 After rst deasserts with button already high, a full press debounce (REQ-020) is required before press_pulse; no press is inferred from the held level.

Verification (DEBOUNCE_MAX=4, LONG_MAX=16)
REQ-025 rst high 3 cycles with button toggling -> all outputs 0 throughout, no pulses.
REQ-026 Clean press held 12 cycles -> press_pulse high for 1 cycle after edge 7, btn_level 1 from then; release_pulse 1 cycle after edge 7 past the first low sample; toggle 0->1.
REQ-027 Bounce: button high 2 cycles, low 3, high 2, low -> no pulses, btn_level stays 0, toggle unchanged.
REQ-028 Two clean short presses -> 2 press_pulse, 2 release_pulse, toggle 0->1->0.
REQ-029 With toggle=1, button held 30 cycles -> exactly one long_pulse, 16 cycles after press_pulse; toggle->0 on it; on release toggle stays 0.
REQ-030 rst pulsed for 1 cycle during HELD with button still high -> next cycle all outputs 0; press_pulse reasserts only after edge 7 counted from the first post-reset edge.
